// File: rtl/opl3_reg_write_ctrl.sv
// OPL3 register-array write controller: decodes host I/O ports, queues data writes,
// commits them to the 512-entry array with enforced spacing, and zero-fills the array after reset.
module opl3_reg_write_ctrl #(
    parameter int CLR_ON_RESET   = 1,
    parameter int WR_BUSY_CYCLES = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       host_wr,
    input  logic [1:0] host_port,
    input  logic [7:0] host_din,
    input  logic       is_new,
    output logic       reg_wr_en,
    output logic [8:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_HOLD
    } state_t;

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
    } wr_entry_t;

    localparam state_t           RESET_STATE = (CLR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic [7:0]       HOLD_LOAD   = 8'(WR_BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [9:0]       CLR_LAST    = 10'd511;

    state_t           state;
    logic [9:0]       clr_cnt;
    logic [7:0]       hold_cnt;
    logic [8:0]       addr_latch;
    logic [8:0]       next_latch;

    wr_entry_t        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    wr_entry_t        fifo_head;

    logic addr_wr;
    logic data_wr;
    logic fifo_empty;
    logic pop;
    logic push;
    logic drop;

    // Host port decode: odd ports carry data, even ports select the bank address.
    assign addr_wr    = host_wr && !host_port[0];
    assign data_wr    = host_wr &&  host_port[0];

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == DEPTH_CNT);
    assign fifo_head  = fifo_mem[rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop        = (state == ST_IDLE) && !fifo_empty;
    assign push       = data_wr && (!fifo_full || pop);
    assign drop       = data_wr &&  fifo_full && !pop;

    assign busy       = (state != ST_IDLE) || !fifo_empty;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        next_latch = addr_latch;
        if (addr_wr) begin
            // With NEW = 0 only 0x105 is reachable in bank1; everything else aliases to bank0.
            if (host_port[1] && (is_new || host_din == 8'h05)) begin
                next_latch = {1'b1, host_din};
            end else begin
                next_latch = {1'b0, host_din};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_latch <= '0;
            overflow   <= 1'b0;
        end else begin
            addr_latch <= next_latch;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: FIFO storage is left unreset; the count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: addr_latch, data: host_din};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RESET_STATE;
            clr_cnt     <= '0;
            hold_cnt    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
        end else begin
            reg_wr_en <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    reg_wr_en   <= 1'b1;
                    reg_wr_addr <= clr_cnt[8:0];
                    reg_wr_data <= '0;
                    if (clr_cnt == CLR_LAST) begin
                        clr_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (pop) begin
                        reg_wr_en   <= 1'b1;
                        reg_wr_addr <= fifo_head.addr;
                        reg_wr_data <= fifo_head.data;
                        hold_cnt    <= HOLD_LOAD;
                        // Single-cycle spacing keeps committing straight from IDLE.
                        if (WR_BUSY_CYCLES > 1) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt == 8'd1) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opl3_reg_write_ctrl.sv
// Self-checking bench for opl3_reg_write_ctrl: a queue-and-cooldown reference model checked every
// cycle, plus literal expectations from directed scenarios, followed by randomized host traffic.
module tb_opl3_reg_write_ctrl;

    localparam int WBC   = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       host_wr = 1'b0;
    logic [1:0] host_port = 2'd0;
    logic [7:0] host_din = 8'd0;
    logic       is_new = 1'b0;
    logic       reg_wr_en;
    logic [8:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    opl3_reg_write_ctrl #(
        .CLR_ON_RESET   (1),
        .WR_BUSY_CYCLES (WBC),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .host_wr     (host_wr),
        .host_port   (host_port),
        .host_din    (host_din),
        .is_new      (is_new),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .busy        (busy),
        .fifo_full   (fifo_full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] addr;
        logic [7:0] data;
        int         cyc;
    } commit_t;

    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    commit_t act_log[$];

    // Reference model: pending writes as a queue, a cooldown count until the next commit is allowed,
    // and the number of zero-fill writes still owed after reset.
    int          m_clear_left;
    logic [16:0] m_q[$];
    int          m_wait;
    logic [8:0]  m_latch;
    logic        m_ovf;
    logic        e_en;
    logic [8:0]  e_addr;
    logic [7:0]  e_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_clear_left = 512;
        m_q.delete();
        m_wait  = 0;
        m_latch = '0;
        m_ovf   = 1'b0;
        e_en    = 1'b0;
        e_addr  = '0;
        e_data  = '0;
    endtask

    task automatic model_edge();
        logic        full_before;
        logic        popped;
        logic [16:0] head;
        full_before = (m_q.size() == DEPTH);
        popped      = 1'b0;
        e_en        = 1'b0;
        if (m_clear_left > 0) begin
            e_en   = 1'b1;
            e_addr = 9'(512 - m_clear_left);
            e_data = 8'h00;
            m_clear_left--;
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (m_q.size() > 0) begin
            head   = m_q.pop_front();
            popped = 1'b1;
            e_en   = 1'b1;
            e_addr = head[16:8];
            e_data = head[7:0];
            m_wait = WBC - 1;
        end
        if (host_wr) begin
            if (host_port[0]) begin
                if (!full_before || popped) m_q.push_back({m_latch, host_din});
                else m_ovf = 1'b1;
            end else if (host_port[1]) begin
                m_latch = (is_new || host_din == 8'h05) ? {1'b1, host_din} : {1'b0, host_din};
            end else begin
                m_latch = {1'b0, host_din};
            end
        end
    endtask

    task automatic compare();
        check("reg_wr_en", reg_wr_en, e_en);
        check("reg_wr_addr", reg_wr_addr, e_addr);
        check("reg_wr_data", reg_wr_data, e_data);
        check("busy", busy, (m_clear_left > 0) || (m_wait > 0) || (m_q.size() > 0));
        check("fifo_full", fifo_full, m_q.size() == DEPTH);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (reset_n) model_edge();
        #1;
        if (reg_wr_en === 1'b1) act_log.push_back('{reg_wr_addr, reg_wr_data, cyc});
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic host_write(input logic [1:0] port, input logic [7:0] din);
        host_wr   = 1'b1;
        host_port = port;
        host_din  = din;
        step();
        host_wr   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        compare();
        check("rst_en", reg_wr_en, 1'b0);
        check("rst_full", fifo_full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int s;
        int nonzero;
        int rate;

        // Power-on reset and full zero-fill.
        model_reset();
        #2;
        compare();
        check("por_addr", reg_wr_addr, 9'h000);
        step();
        step();
        reset_n = 1'b1;
        act_log.delete();
        run(514);
        check("clear_count", act_log.size(), 512);
        nonzero = 0;
        for (int i = 0; i < act_log.size(); i++) begin
            if (act_log[i].addr != 9'(i) || act_log[i].data != 8'h00) nonzero++;
        end
        check("clear_sequence", nonzero, 0);
        if (act_log.size() == 512) begin
            check("clear_first_addr", act_log[0].addr, 9'h000);
            check("clear_last_addr", act_log[511].addr, 9'h1FF);
            check("clear_span", act_log[511].cyc - act_log[0].cyc, 511);
        end
        check("busy_after_clear", busy, 1'b0);

        // Single write through bank0 address port.
        act_log.delete();
        host_write(2'd0, 8'hA0);
        host_write(2'd1, 8'h44);
        s = cyc;
        run(12);
        check("single_count", act_log.size(), 1);
        if (act_log.size() >= 1) begin
            check("single_addr", act_log[0].addr, 9'h0A0);
            check("single_data", act_log[0].data, 8'h44);
            check("single_latency", act_log[0].cyc, s + 1);
        end

        // OPL2 compatibility aliasing of bank1 addresses.
        is_new = 1'b0;
        act_log.delete();
        host_write(2'd2, 8'hB0);
        host_write(2'd1, 8'h21);
        run(10);
        host_write(2'd2, 8'h05);
        host_write(2'd1, 8'h01);
        run(10);
        is_new = 1'b1;
        host_write(2'd2, 8'hB0);
        host_write(2'd1, 8'h21);
        run(10);
        check("alias_count", act_log.size(), 3);
        if (act_log.size() == 3) begin
            check("alias_b0_new0", act_log[0].addr, 9'h0B0);
            check("alias_105", act_log[1].addr, 9'h105);
            check("alias_b0_new1", act_log[2].addr, 9'h1B0);
        end

        // Four back-to-back data writes reuse the latch and commit WBC cycles apart.
        act_log.delete();
        for (int i = 0; i < 4; i++) host_write(2'd3, 8'(8'h10 + i));
        run(40);
        check("spacing_count", act_log.size(), 4);
        if (act_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("spacing_addr", act_log[i].addr, 9'h1B0);
                check("spacing_data", act_log[i].data, 8'(8'h10 + i));
                if (i > 0) check("spacing_gap", act_log[i].cyc - act_log[i-1].cyc, WBC);
            end
        end

        // Six writes during CLEAR: four queued, two dropped, overflow sticks.
        do_reset();
        act_log.delete();
        run(3);
        for (int i = 0; i < 6; i++) begin
            host_write(2'd1, 8'(8'h60 + i));
            if (i == 3) check("clear_fifo_full", fifo_full, 1'b1);
        end
        run(560);
        check("ovf_total_commits", act_log.size(), 516);
        if (act_log.size() == 516) begin
            for (int i = 0; i < 4; i++) begin
                check("ovf_order_addr", act_log[512+i].addr, 9'h000);
                check("ovf_order_data", act_log[512+i].data, 8'(8'h60 + i));
            end
        end
        check("ovf_set", overflow, 1'b1);
        run(20);
        check("ovf_sticky", overflow, 1'b1);

        // Reset during HOLD with three entries queued: nothing stale after the restarted CLEAR.
        for (int i = 0; i < 4; i++) host_write(2'd1, 8'(8'h70 + i));
        check("hold_busy", busy, 1'b1);
        do_reset();
        act_log.delete();
        run(600);
        check("no_stale_commits", act_log.size(), 512);

        // Randomized host traffic with varying density and NEW bit.
        rate = 20;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) rate = int'($urandom_range(60, 5));
            if (i % 97 == 0) is_new = 1'($urandom_range(1, 0));
            if (i == 2000) begin
                do_reset();
            end
            if (int'($urandom_range(99, 0)) < rate) begin
                host_wr   = 1'b1;
                host_port = 2'($urandom_range(3, 0));
                host_din  = 8'($urandom);
                if ($urandom_range(3, 0) == 0) host_din = 8'h05;
            end else begin
                host_wr = 1'b0;
            end
            step();
        end
        host_wr = 1'b0;
        run(60);
        check("drain_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/opl3_reg_write_ctrl.md
Name: opl3_reg_write_ctrl

Overview:
- Owns the 512-entry OPL3 register array (bank0 0x000–0x0FF, bank1 0x100–0x1FF). It is the only writer to that array.
- Decodes the four host I/O ports into address-latch and data writes, and buffers data writes in a small FIFO.
- Commits one write per cycle to the array, then enforces a minimum spacing between commits.
- After reset, zero-fills the whole array so the downstream per-operator register decode starts from a known state.

Parameters:
- CLR_ON_RESET, 1, 1 = run the 512-cycle zero-fill after reset; 0 = skip it and enter IDLE directly.
- WR_BUSY_CYCLES, 8, cycles from one commit to the next commit (range 1–255).
- FIFO_DEPTH, 4, data-write FIFO entries (power of 2, ≥ 2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- host_wr  in  1  one-cycle host write strobe.
- host_port  in  2  0 = bank0 address, 1 = data, 2 = bank1 address, 3 = data.
- host_din  in  8  host write data.
- is_new  in  1  current value of register 0x105 bit0, fed back from the array.
- reg_wr_en  out  1  array write enable, one-cycle pulse.
- reg_wr_addr  out  9  array write address.
- reg_wr_data  out  8  array write data.
- busy  out  1  1 = state ≠ IDLE or FIFO not empty.
- fifo_full  out  1  1 = FIFO holds FIFO_DEPTH entries.
- overflow  out  1  sticky; set when a data write is dropped.

Behaviour:
- Reset values (async on reset_n low):
  - reg_wr_en = 0, reg_wr_addr = 0, reg_wr_data = 0, overflow = 0.
  - Address latch = 0x000, FIFO empty.
  - State = CLEAR if CLR_ON_RESET = 1, else IDLE.
- Address latch, updated on host_wr to port 0 or 2:
  - Port 0: latch = {0, host_din}.
  - Port 2: latch = {1, host_din}.
  - If is_new = 0 and the port-2 value ≠ 0x05: latch = {0, host_din}. This is OPL2 compatibility; only 0x105 is reachable while NEW = 0.
- Data write (host_wr to port 1 or 3):
  - Pushes {latch, host_din} into the FIFO.
  - The latch is unchanged, so repeated data writes reuse the same address.
- FIFO full on a data write:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the write is dropped and overflow is set.
  - Host writes are accepted in every state, including CLEAR.
- State machine:
  - CLEAR:
    - reg_wr_en = 1 every cycle, reg_wr_data = 0.
    - reg_wr_addr counts 0 to 511 over 512 consecutive cycles.
    - After the address-511 cycle, go to IDLE. The FIFO is not popped during CLEAR.
  - IDLE:
    - If the FIFO is not empty: pop the head, drive reg_wr_en = 1 with the popped address and data in the same cycle, load spacing counter = WR_BUSY_CYCLES-1, go to HOLD.
    - Exception: if WR_BUSY_CYCLES = 1, stay in IDLE so back-to-back commits happen every cycle.
  - HOLD:
    - reg_wr_en = 0; decrement the counter.
    - When the counter reaches 0 (counter = 1 → 0 transition), go to IDLE. The next commit therefore lands exactly WR_BUSY_CYCLES cycles after the previous one.
- Timing:
  - Host-to-array latency with an empty FIFO in IDLE: the push is registered in cycle N and the commit occurs in cycle N+1.
  - reg_wr_addr and reg_wr_data hold their last values when reg_wr_en = 0.
- Reset asserted mid-operation:
  - Any in-progress CLEAR or HOLD is abandoned and all FIFO contents are lost.
  - CLEAR restarts from address 0 after release.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH; the CLEAR counter is 10 bits, terminating at 511.

Test Plan:
- Reset release, CLR_ON_RESET = 1 → 512 consecutive reg_wr_en pulses, addresses 0x000..0x1FF, data 0x00; then busy = 0 at cycle 513.
- In IDLE, port0 ← 0xA0 then port1 ← 0x44 → exactly one commit, addr 0x0A0, data 0x44, one cycle after the data strobe.
- is_new = 0, port2 ← 0xB0, port1 ← 0x21 → commit addr 0x0B0. Then port2 ← 0x05, port1 ← 0x01 → commit addr 0x105. Then with is_new = 1, port2 ← 0xB0, port1 ← 0x21 → commit addr 0x1B0.
- WR_BUSY_CYCLES = 8, four data writes on consecutive cycles → commits spaced exactly 8 cycles apart, in order; fifo_full = 1 after the fourth push if the first has not yet been popped.
- FIFO_DEPTH = 4, six back-to-back data writes during CLEAR → the first four are committed after CLEAR in order, the last two are dropped, overflow = 1 and stays set until reset.
- reset_n pulsed low during HOLD with 3 entries queued → outputs return to reset values, the FIFO is empty, and no stale commit is issued after the restarted CLEAR.
